// File: rtl/bcd_ex3_seq.sv
// Sequential packed-BCD to Excess-3 converter.
// A word is captured in IDLE. One digit per cycle then passes, LSB digit first,
// through a single shared 4-bit converter. The finished word is held in DONE
// until the consumer takes it.
module bcd_ex3_seq #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   ex3_out,
    output logic                  err,
    output logic                  busy
);

    localparam int W     = 4 * DIGITS;
    // One spare bit lets the index reach DIGITS without wrapping.
    localparam int IDX_W = $clog2(DIGITS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [W-1:0]     in_reg;
    logic [W-1:0]     res_reg;
    logic             err_reg;
    logic [IDX_W-1:0] idx;

    logic [3:0]       cur_digit;
    logic [3:0]       cur_ex3;
    logic             cur_bad;
    logic             last_digit;

    // A non-BCD digit (10..15) maps to the all-ones marker 4'hF.
    function automatic logic [3:0] ex3_digit(input logic [3:0] d);
        if (d > 4'd9) begin
            return 4'hF;
        end
        return d + 4'd3;
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return (d > 4'd9);
    endfunction

    // Select the digit addressed by idx and feed it to the one shared converter.
    always_comb begin
        cur_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_digit = in_reg[i*4 +: 4];
            end
        end
        cur_ex3    = ex3_digit(cur_digit);
        cur_bad    = digit_invalid(cur_digit);
        last_digit = (idx == IDX_W'(DIGITS - 1));
    end

    assign ex3_out = res_reg;
    assign err     = err_reg;

    // Control FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_reg    <= '0;
            res_reg   <= '0;
            err_reg   <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is ignored here; a pending word is accepted normally.
                    if (in_valid) begin
                        in_reg   <= bcd_in;
                        res_reg  <= '0;
                        err_reg  <= 1'b0;
                        idx      <= '0;
                        state    <= CONV;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CONV: begin
                    if (abort) begin
                        // Leave the partial result untouched; it is simply discarded.
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        for (int i = 0; i < DIGITS; i++) begin
                            if (idx == IDX_W'(i)) begin
                                res_reg[i*4 +: 4] <= cur_ex3;
                            end
                        end
                        if (cur_bad) begin
                            err_reg <= 1'b1;
                        end
                        idx <= idx + 1'b1;
                        if (last_digit) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    // abort wins over the handshake; both lead back to IDLE
                    // without touching the held result.
                    if (abort) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end else if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_ex3_seq.sv
// Bench for bcd_ex3_seq: directed cases plus randomized words checked against
// a digit-by-digit arithmetic reference model.
module tb_bcd_ex3_seq;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         abort = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] bcd_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic         err;
    logic         busy;
    logic [W-1:0] ex3_out;

    int checks = 0;
    int failures = 0;

    bcd_ex3_seq #(.DIGITS(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ex3_out   (ex3_out),
        .err       (err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: each digit d -> d+3 when d<=9, else 15.
    function automatic logic [W-1:0] ref_ex3(input logic [W-1:0] w);
        logic [W-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < D; i++) begin
            d = int'((w >> (4 * i)) & W'(15));
            r = r | (W'((d > 9) ? 15 : d + 3) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic ref_err(input logic [W-1:0] w);
        int d;
        for (int i = 0; i < D; i++) begin
            d = int'((w >> (4 * i)) & W'(15));
            if (d > 9) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word, check latency and result, then drain it after a stall.
    task automatic run_word(input logic [W-1:0] w, input int stall, input bit abort_idle, input string tag);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_rdy"}, W'(in_ready), W'(1));
        bcd_in   = w;
        in_valid = 1'b1;
        abort    = abort_idle;
        tick();
        in_valid = 1'b0;
        abort    = 1'b0;
        check({tag, "_busy"}, W'(busy), W'(1));
        n = 0;
        while (!out_valid && n < 20) begin
            in_valid = 1'($urandom_range(0, 1));
            bcd_in   = W'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check({tag, "_lat"}, W'(n), W'(D));
        check({tag, "_ex3"}, ex3_out, ref_ex3(w));
        check({tag, "_err"}, W'(err), W'(ref_err(w)));
        out_ready = 1'b0;
        repeat (stall) tick();
        check({tag, "_hold"}, ex3_out, ref_ex3(w));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_drain"}, W'(out_valid), W'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] exp_hold;
        logic         exp_err;
        int           n;
        bit           seen;

        // Reset state
        #1 rst_n = 1'b0;
        #10;
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_err", W'(err), W'(0));
        check("rst_ex3", ex3_out, '0);
        #2 rst_n = 1'b1;

        // First accept right after release, then the listed words
        run_word(16'h1234, 0, 1'b0, "w1234");
        run_word(16'h0999, 1, 1'b0, "w0999");
        run_word(16'h0000, 0, 1'b0, "w0000");
        run_word(16'h12A4, 2, 1'b0, "w12a4");
        run_word(16'h5678, 0, 1'b0, "w5678");

        // Long stall in DONE with ignored in_valid pulses
        w = 16'h3141;
        bcd_in = w; in_valid = 1'b1; tick(); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        exp_hold = ref_ex3(w);
        exp_err  = ref_err(w);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            bcd_in   = 16'h9999;
            tick();
            check("stall_ov", W'(out_valid), W'(1));
            check("stall_ex3", ex3_out, exp_hold);
            check("stall_err", W'(err), W'(exp_err));
            check("stall_ir", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("stall_done_ov", W'(out_valid), W'(0));
        check("stall_done_ir", W'(in_ready), W'(1));
        check("stall_keep_ex3", ex3_out, exp_hold);

        // Abort in the second CONV cycle
        bcd_in = 16'h1111; in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check("ab2_ir", W'(in_ready), W'(1));
        check("ab2_busy", W'(busy), W'(0));
        check("ab2_ex3", ex3_out, 16'h0004);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); seen = seen | out_valid; end
        check("ab2_no_ov", W'(seen), W'(0));
        run_word(16'h9876, 0, 1'b0, "w9876");

        // Abort together with completion in the last CONV cycle
        bcd_in = 16'h2222; in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (3) tick();
        abort = 1'b1; out_ready = 1'b1; tick(); abort = 1'b0; out_ready = 1'b0;
        check("ablast_ov", W'(out_valid), W'(0));
        check("ablast_ir", W'(in_ready), W'(1));
        check("ablast_ex3", ex3_out, 16'h0555);

        // Abort in DONE keeps the result on ex3_out
        bcd_in = 16'h0123; in_valid = 1'b1; tick(); in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin tick(); n++; end
        abort = 1'b1; tick(); abort = 1'b0;
        check("abdone_ov", W'(out_valid), W'(0));
        check("abdone_ir", W'(in_ready), W'(1));
        check("abdone_ex3", ex3_out, 16'h3456);

        // Abort in IDLE does not block a simultaneous accept
        run_word(16'h4321, 0, 1'b1, "abidle");

        // Asynchronous reset between edges mid-CONV
        bcd_in = 16'h5555; in_valid = 1'b1; tick(); in_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("arst_ir", W'(in_ready), W'(1));
        check("arst_ov", W'(out_valid), W'(0));
        check("arst_busy", W'(busy), W'(0));
        check("arst_err", W'(err), W'(0));
        check("arst_ex3", ex3_out, '0);
        #2 rst_n = 1'b1;
        check("arst_rel_ir", W'(in_ready), W'(1));
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin tick(); seen = seen | out_valid; end
        check("arst_no_ov", W'(seen), W'(0));

        // Randomized words, occasionally carrying non-BCD digits
        for (int k = 0; k < 40; k++) begin
            w = '0;
            for (int i = 0; i < D; i++) begin
                if ($urandom_range(0, 7) == 0)
                    w = w | (W'(10 + $urandom_range(0, 5)) << (4 * i));
                else
                    w = w | (W'($urandom_range(0, 9)) << (4 * i));
            end
            run_word(w, int'($urandom_range(0, 3)), 1'b0, "rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
